// File: rtl/bank_arbiter_pkg.sv
// Shared constants for the bank arbiter slice.
// Holds default sizes and the requester-id width helper.
package bank_arbiter_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 8;
  localparam int DW_DEF   = 8;
  localparam int ID_W     = $clog2(NREQ_DEF);

  // Requester-id width for a given requester count.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bank_arbiter_rr_arbiter.sv
// Round-robin selector: req, ptr in; one-hot gnt and id out.
// Purely combinational; search starts at ptr and wraps.
module rr_arbiter
  import bank_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   id
);

  logic [IW-1:0] idx;
  logic          found;

  // NREQ is a power of two, so ptr+k wraps mod NREQ.
  always_comb begin
    gnt   = '0;
    id    = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + IW'(k);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        id       = idx;
      end
    end
  end

endmodule

// File: rtl/bank_arbiter.sv
// Shares one single-port bank among NREQ requesters.
// Ports: req/we/addr/wdata in, gnt/rvalid/rdata/err out, bank cmd/resp.
module bank_arbiter
  import bank_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    we_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*DW-1:0] wdata_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    rvalid_o,
  output logic [DW-1:0]      rdata_o,
  output logic [AW-1:0]      bank_addr,
  output logic [DW-1:0]      bank_data_in,
  output logic               bank_read_enable,
  output logic               bank_write_enable,
  input  logic [DW-1:0]      bank_data_out,
  input  logic               bank_valid_out,
  output logic               err_o
);

  localparam int IW = id_width(NREQ);

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win_id;
  logic [IW-1:0]   cmd_id;
  logic [IW-1:0]   fl_id;
  logic [NREQ-1:0] rr_gnt;
  logic            any;
  logic            win_we;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;
  logic            fl_vld;
  logic            armed;
  logic            hit;
  logic            err_q;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req (req_i),
    .ptr (ptr),
    .gnt (rr_gnt),
    .id  (win_id)
  );

  assign any       = |rr_gnt;
  assign gnt_o     = reset ? rr_gnt : '0;
  assign win_we    = we_i[win_id];
  assign win_addr  = addr_i[win_id*AW +: AW];
  assign win_wdata = wdata_i[win_id*DW +: DW];

  // fl_* tracks the read the bank is answering this cycle.
  assign hit      = bank_valid_out & fl_vld;
  assign rvalid_o = hit ? (NREQ'(1) << fl_id) : '0;
  assign rdata_o  = hit ? bank_data_out : '0;
  assign err_o    = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr               <= '0;
      cmd_id            <= '0;
      fl_id             <= '0;
      fl_vld            <= 1'b0;
      armed             <= 1'b0;
      err_q             <= 1'b0;
      bank_addr         <= '0;
      bank_data_in      <= '0;
      bank_read_enable  <= 1'b0;
      bank_write_enable <= 1'b0;
    end else begin
      armed             <= 1'b1;
      bank_read_enable  <= any & ~win_we;
      bank_write_enable <= any & win_we;
      if (any) begin
        ptr          <= win_id + IW'(1);
        cmd_id       <= win_id;
        bank_addr    <= win_addr;
        bank_data_in <= win_wdata;
      end
      fl_vld <= bank_read_enable;
      fl_id  <= cmd_id;
      // Stale bank response right after reset is not an error.
      if (bank_valid_out && !fl_vld && armed)
        err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bank_arbiter.sv
// Directed bench for bank_arbiter with a small bank model.
// Table rows are one cycle each; corner cases are hand sequences.
module tb_bank_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_i;
  logic [3:0]  we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  gnt_o;
  logic [3:0]  rvalid_o;
  logic [7:0]  rdata_o;
  logic [7:0]  bank_addr;
  logic [7:0]  bank_data_in;
  logic        bank_read_enable;
  logic        bank_write_enable;
  logic [7:0]  bank_data_out;
  logic        bank_valid_out;
  logic        err_o;

  int total;
  int bad;

  logic [7:0] mem [256];
  logic [7:0] rd_q;
  logic       vq;
  logic       inject;
  logic       init_mem;

  bank_arbiter #(.NREQ(4), .AW(8), .DW(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_i             (req_i),
    .we_i              (we_i),
    .addr_i            (addr_i),
    .wdata_i           (wdata_i),
    .gnt_o             (gnt_o),
    .rvalid_o          (rvalid_o),
    .rdata_o           (rdata_o),
    .bank_addr         (bank_addr),
    .bank_data_in      (bank_data_in),
    .bank_read_enable  (bank_read_enable),
    .bank_write_enable (bank_write_enable),
    .bank_data_out     (bank_data_out),
    .bank_valid_out    (bank_valid_out),
    .err_o             (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank: mem[a] starts as a+1, read data one cycle after enable.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i + 1);
      vq   <= 1'b0;
      rd_q <= 8'h00;
    end else begin
      if (bank_write_enable) mem[bank_addr] <= bank_data_in;
      if (bank_read_enable) rd_q <= mem[bank_addr];
      vq <= bank_read_enable;
    end
  end

  assign bank_valid_out = vq | inject;
  assign bank_data_out  = rd_q;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [7:0]  rdata;
    logic        rd_en;
    logic        wr_en;
    logic [7:0]  baddr;
    logic [7:0]  bdata;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic [3:0] rq, input logic [3:0] w,
    input logic [31:0] a, input logic [31:0] wd,
    input logic [3:0] g, input logic [3:0] rv,
    input logic [7:0] rd, input logic re, input logic wr,
    input logic [7:0] ba, input logic [7:0] bd);
    vec_t v;
    v.req = rq; v.we = w; v.addr = a; v.wdata = wd;
    v.gnt = g; v.rvalid = rv; v.rdata = rd;
    v.rd_en = re; v.wr_en = wr; v.baddr = ba; v.bdata = bd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    init_mem = 1'b1;
    inject = 1'b1;
    req_i = 4'hF;
    we_i = 4'h0;
    addr_i = 32'h0;
    wdata_i = 32'h0;

    // r0..r2 single read; r3..r6 write then read same addr;
    // r7..r11 same-cycle read/write to 255; r12..r20 all four.
    tbl[0]  = mk(4'h1, 4'h0, 32'h00000009, 32'h0, 4'h1, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    tbl[1]  = mk(4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h09, 8'h00);
    tbl[2]  = mk(4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h1, 8'h0A, 1'b0, 1'b0, 8'h09, 8'h00);
    tbl[3]  = mk(4'h2, 4'h2, 32'h00000900, 32'h00001800, 4'h2, 4'h0, 8'h00, 1'b0, 1'b0, 8'h09, 8'h00);
    tbl[4]  = mk(4'h8, 4'h0, 32'h09000000, 32'h0, 4'h8, 4'h0, 8'h00, 1'b0, 1'b1, 8'h09, 8'h18);
    tbl[5]  = mk(4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 8'h09, 8'h00);
    tbl[6]  = mk(4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h8, 8'h18, 1'b0, 1'b0, 8'h09, 8'h00);
    tbl[7]  = mk(4'h5, 4'h4, 32'h00FF00FF, 32'h00910000, 4'h1, 4'h0, 8'h00, 1'b0, 1'b0, 8'h09, 8'h00);
    tbl[8]  = mk(4'h4, 4'h4, 32'h00FF00FF, 32'h00910000, 4'h4, 4'h0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00);
    tbl[9]  = mk(4'h1, 4'h0, 32'h000000FF, 32'h0, 4'h1, 4'h1, 8'h00, 1'b0, 1'b1, 8'hFF, 8'h91);
    tbl[10] = mk(4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00);
    tbl[11] = mk(4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h1, 8'h91, 1'b0, 1'b0, 8'hFF, 8'h00);
    tbl[12] = mk(4'h8, 4'h0, 32'h03000000, 32'h0, 4'h8, 4'h0, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h00);
    tbl[13] = mk(4'hF, 4'h0, 32'h04030201, 32'h0, 4'h1, 4'h0, 8'h00, 1'b1, 1'b0, 8'h03, 8'h00);
    tbl[14] = mk(4'hF, 4'h0, 32'h04030201, 32'h0, 4'h2, 4'h8, 8'h04, 1'b1, 1'b0, 8'h01, 8'h00);
    tbl[15] = mk(4'hF, 4'h0, 32'h04030201, 32'h0, 4'h4, 4'h1, 8'h02, 1'b1, 1'b0, 8'h02, 8'h00);
    tbl[16] = mk(4'hF, 4'h0, 32'h04030201, 32'h0, 4'h8, 4'h2, 8'h03, 1'b1, 1'b0, 8'h03, 8'h00);
    tbl[17] = mk(4'hF, 4'h0, 32'h04030201, 32'h0, 4'h1, 4'h4, 8'h04, 1'b1, 1'b0, 8'h04, 8'h00);
    tbl[18] = mk(4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h8, 8'h05, 1'b1, 1'b0, 8'h01, 8'h00);
    tbl[19] = mk(4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h1, 8'h02, 1'b0, 1'b0, 8'h01, 8'h00);
    tbl[20] = mk(4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0, 8'h01, 8'h00);

    // Reset state, with requests and a stray bank valid present.
    repeat (3) @(posedge clk);
    #1;
    chk("rst gnt", 32'(gnt_o), 32'h0);
    chk("rst rvalid", 32'(rvalid_o), 32'h0);
    chk("rst rdata", 32'(rdata_o), 32'h0);
    chk("rst rd_en", 32'(bank_read_enable), 32'h0);
    chk("rst wr_en", 32'(bank_write_enable), 32'h0);
    chk("rst baddr", 32'(bank_addr), 32'h0);
    chk("rst bdata", 32'(bank_data_in), 32'h0);
    chk("rst err", 32'(err_o), 32'h0);
    inject = 1'b0;
    init_mem = 1'b0;
    req_i = 4'h0;
    tick();
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      req_i = tbl[i].req;
      we_i = tbl[i].we;
      addr_i = tbl[i].addr;
      wdata_i = tbl[i].wdata;
      #2;
      chk($sformatf("r%0d gnt", i), 32'(gnt_o), 32'(tbl[i].gnt));
      chk($sformatf("r%0d rvalid", i), 32'(rvalid_o), 32'(tbl[i].rvalid));
      if (tbl[i].rvalid != 4'h0)
        chk($sformatf("r%0d rdata", i), 32'(rdata_o), 32'(tbl[i].rdata));
      chk($sformatf("r%0d rd_en", i), 32'(bank_read_enable), 32'(tbl[i].rd_en));
      chk($sformatf("r%0d wr_en", i), 32'(bank_write_enable), 32'(tbl[i].wr_en));
      chk($sformatf("r%0d baddr", i), 32'(bank_addr), 32'(tbl[i].baddr));
      if (tbl[i].wr_en)
        chk($sformatf("r%0d bdata", i), 32'(bank_data_in), 32'(tbl[i].bdata));
      chk($sformatf("r%0d err", i), 32'(err_o), 32'h0);
      tick();
    end

    // Unsolicited bank valid: sticky error, no return strobe.
    req_i = 4'h0;
    inject = 1'b1;
    #2;
    chk("orphan rvalid", 32'(rvalid_o), 32'h0);
    tick();
    inject = 1'b0;
    #1;
    chk("orphan err", 32'(err_o), 32'h1);
    repeat (3) tick();
    chk("orphan err sticky", 32'(err_o), 32'h1);
    chk("orphan rvalid idle", 32'(rvalid_o), 32'h0);

    // Reset clears the error asynchronously.
    reset = 1'b0;
    #2;
    chk("err clr", 32'(err_o), 32'h0);
    tick();
    reset = 1'b1;

    // Read granted, then reset before it returns.
    req_i = 4'h1;
    we_i = 4'h0;
    addr_i = 32'h00000009;
    #2;
    chk("mid gnt", 32'(gnt_o), 32'h1);
    tick();
    req_i = 4'h0;
    reset = 1'b0;
    #2;
    chk("mid rd_en", 32'(bank_read_enable), 32'h0);
    chk("mid rvalid", 32'(rvalid_o), 32'h0);
    tick();
    reset = 1'b1;
    inject = 1'b1;
    #2;
    chk("post rvalid", 32'(rvalid_o), 32'h0);
    tick();
    inject = 1'b0;
    #1;
    chk("post err", 32'(err_o), 32'h0);
    req_i = 4'hF;
    #1;
    chk("post ptr0", 32'(gnt_o), 32'h1);
    tick();
    req_i = 4'h0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("post rv%0d", k), 32'(rvalid_o), 32'(k == 1 ? 4'h1 : 4'h0));
      chk($sformatf("post err%0d", k), 32'(err_o), 32'h0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bank_arbiter.md
BANK_ARBITER -- requirements
Module: bank_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (power of 2, 2..8).
REQ-002 Parameter AW, default 8, bank address width.
REQ-003 Parameter DW, default 8, bank data width.
REQ-004 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  in  1  reset, asynchronous, active-low.
REQ-006 Port req_i  in  NREQ  per-requester request; held until granted.
REQ-007 Port we_i  in  NREQ  per-requester write (1) / read (0) select.
REQ-008 Port addr_i  in  NREQ*AW  per-requester address, slot i at bits [i*AW +: AW].
REQ-009 Port wdata_i  in  NREQ*DW  per-requester write data, same packing.
REQ-010 Port gnt_o  out  NREQ  one-hot grant, combinational, same cycle as the winning request.
REQ-011 Port rvalid_o  out  NREQ  one-hot read-return strobe.
REQ-012 Port rdata_o  out  DW  read data, shared by all requesters; qualified by rvalid_o.
REQ-013 Port bank_addr  out  AW  registered address to bank.
REQ-014 Port bank_data_in  out  DW  registered write data to bank.
REQ-015 Port bank_read_enable  out  1  registered bank read strobe.
REQ-016 Port bank_write_enable  out  1  registered bank write strobe.
REQ-017 Port bank_data_out  in  DW  bank read data.
REQ-018 Port bank_valid_out  in  1  bank read-data valid, one cycle after bank_read_enable.
REQ-019 Port err_o  out  1  sticky: bank_valid_out arrived with no read in flight.

Function
REQ-020 Cycle N: among asserted req_i, the arbiter SHALL grant exactly one, round-robin, search starting at ptr.
REQ-021 Grant to i SHALL set ptr to (i+1) mod NREQ at the end of cycle N; no request means ptr unchanged and gnt_o = 0.
REQ-022 Cycle N+1: bank command SHALL carry the winner's addr/wdata, write_enable = we_i, read_enable = ~we_i; otherwise both enables 0 and bank_addr/bank_data_in hold their last values.
REQ-023 A read granted in cycle N SHALL record tag i in a one-entry in-flight register valid in cycle N+1.
REQ-024 Cycle N+2: bank_valid_out with a valid tag SHALL drive rvalid_o[tag] = 1 and rdata_o = bank_data_out (combinational pass-through); tag SHALL then clear unless a new read replaced it.
REQ-025 Grants SHALL be issuable every cycle; back-to-back reads from different or same requester SHALL return in order, one per cycle.
REQ-026 Requester holding req_i after gnt_o SHALL be treated as a new request, re-arbitrated from the updated ptr.
REQ-027 Writes SHALL produce no return; a read after a write to the same address, granted later, SHALL see the written data (bank order preserved).
REQ-028 bank_valid_out with no valid tag SHALL set err_o and assert no rvalid_o.
REQ-029 rvalid_o SHALL never be asserted for more than one requester in a cycle.
REQ-030 With all NREQ requesting continuously, each SHALL be granted exactly once per NREQ cycles.

Reset
REQ-031 While reset low: gnt_o = 0, rvalid_o = 0, rdata_o = 0, bank enables = 0, bank_addr = 0, bank_data_in = 0, ptr = 0, tag invalid, err_o = 0.
REQ-032 Reset asserted mid-operation SHALL discard in-flight reads; a bank_valid_out in the first cycle after release SHALL be ignored without setting err_o.

Structure
REQ-033 Shared package SHALL hold NREQ/AW/DW defaults and requester-id width constant (clog2 NREQ).
REQ-034 Round-robin selection SHALL be a sub-module rr_arbiter (req, ptr in; one-hot grant, id out), purely combinational; ptr, command and tag registers live in bank_arbiter.

Verification
REQ-035 Reset release, req_i=0001 read addr 9 -> gnt_o=0001 same cycle, bank_read_enable=1 addr 9 next cycle, rvalid_o=0001 two cycles later.
REQ-036 Req 0010 write addr 9 data 24, then req 1000 read addr 9 -> rvalid_o=1000, rdata_o=24.
REQ-037 All four requesting reads continuously, ptr=0 -> grant order 0,1,2,3,0..., rvalid_o follows same order two cycles behind.
REQ-038 Requester 2 writes addr 255 data 145 and requester 0 reads addr 255 in same cycle, ptr=0 -> read first (old data), write next cycle; re-read returns 145.
REQ-039 Inject bank_valid_out=1 with no read pending -> err_o=1 and stays 1 until reset; rvalid_o=0.
REQ-040 Assert reset one cycle after a read grant -> no rvalid_o after release, err_o=0, ptr=0.
